// File: rtl/serial_out_arbiter.sv
// serial_out_arbiter
//   Shares one serial output pin between two word producers (requester 0:
//   output register, requester 1: register-file dump). Grants round-robin in
//   IDLE, captures the granted word on valid/ready, shifts it out MSB-first
//   with a one-cycle start pulse and a source-ID bit, then holds GAP_CYCLES
//   idle cycles before returning to IDLE.
//
//   Optional build macro SERIAL_ARB_PARITY_EN appends one even-parity bit
//   (XOR of all data bits) after the last data bit of each frame.
//
// Parameters
//   WIDTH       data bits per frame (>= 2)
//   GAP_CYCLES  idle cycles forced after each frame (>= 0)
//
// Ports
//   clk, rst_n             fast system clock, async active-low reset
//   req0_valid/data/ready  requester 0 handshake (ready is combinational)
//   req1_valid/data/ready  requester 1 handshake (ready is combinational)
//   serial_out             registered serial data, MSB first
//   start                  registered, high during the first bit of a frame
//   src_id                 registered, source of the current frame
//   busy                   registered, high in SHIFT and GAP
module serial_out_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             start,
  output logic             src_id,
  output logic             busy
);

`ifdef SERIAL_ARB_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FLEN + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_n;
  logic [FLEN-1:0]  shreg, shreg_n, frame;
  logic [WIDTH-1:0] sel_data;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             last_grant, last_grant_n;
  logic             src_n, so_n, start_n, busy_n;
  logic             grant0, grant1;

  // On a tie the requester that was not granted last wins.
  assign grant0     = req0_valid & (~req1_valid | last_grant);
  assign grant1     = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;

  assign sel_data = req1_ready ? req1_data : req0_data;
`ifdef SERIAL_ARB_PARITY_EN
  assign frame = {sel_data, ^sel_data};
`else
  assign frame = sel_data;
`endif

  // Outputs are computed one cycle ahead and registered, so the first bit
  // appears in the cycle after the handshake and nothing is combinational
  // from the request inputs to the serial pins.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    last_grant_n = last_grant;
    src_n        = src_id;
    so_n         = 1'b0;
    start_n      = 1'b0;
    busy_n       = 1'b0;
    case (state)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          state_n      = SHIFT;
          so_n         = frame[FLEN-1];
          shreg_n      = frame << 1;
          bit_cnt_n    = CW'(1);
          start_n      = 1'b1;
          busy_n       = 1'b1;
          last_grant_n = req1_ready;
          src_n        = req1_ready;
        end
      end
      SHIFT: begin
        if (bit_cnt == CW'(FLEN)) begin
          if (GAP_CYCLES > 0) begin
            state_n   = GAP;
            gap_cnt_n = GW'(1);
            busy_n    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          so_n      = shreg[FLEN-1];
          shreg_n   = shreg << 1;
          bit_cnt_n = bit_cnt + 1'b1;
          busy_n    = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES)) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
          busy_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      src_id     <= 1'b0;
      serial_out <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      last_grant <= last_grant_n;
      src_id     <= src_n;
      serial_out <= so_n;
      start      <= start_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_serial_out_arbiter.sv
// tb_serial_out_arbiter
//   Scoreboard bench for serial_out_arbiter. Instance a uses the default
//   parameters (WIDTH=8, GAP_CYCLES=1); instance b uses GAP_CYCLES=0.
//   Expected frames are pushed by the stimulus code; a monitor process pops
//   one entry whenever a DUT raises start and checks the whole frame.
//   Honours SERIAL_ARB_PARITY_EN the same way the design does.
module tb_serial_out_arbiter;

`ifdef SERIAL_ARB_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W     = 8;
  localparam int GAP_A = 1;
  localparam int GAP_B = 0;
  localparam int FLEN  = W + PAR;
  localparam int SP_A  = W + GAP_A + 1 + PAR;
  localparam int SP_B  = W + GAP_B + 1 + PAR;

  typedef struct {
    int         dut;
    int         src;
    logic [7:0] data;
    int         spacing;
    int         nbits;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       a_r0v = 1'b0, a_r1v = 1'b0, a_r0r, a_r1r;
  logic [7:0] a_r0d = '0, a_r1d = '0;
  logic       a_so, a_st, a_src, a_busy;
  logic       b_r0v = 1'b0, b_r1v = 1'b0, b_r0r, b_r1r;
  logic [7:0] b_r0d = '0, b_r1d = '0;
  logic       b_so, b_st, b_src, b_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_a = 0, hs_b = 0;
  int rdy_a0 = 0, rdy_a1 = 0;
  int last_hs[2];
  int last_start[2];
  bit mon_busy = 1'b0;
  frame_t exp_q[$];

  serial_out_arbiter #(.WIDTH(W), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_r0v), .req0_data(a_r0d), .req0_ready(a_r0r),
    .req1_valid(a_r1v), .req1_data(a_r1d), .req1_ready(a_r1r),
    .serial_out(a_so), .start(a_st), .src_id(a_src), .busy(a_busy)
  );

  serial_out_arbiter #(.WIDTH(W), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0r),
    .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1r),
    .serial_out(b_so), .start(b_st), .src_id(b_src), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic so_of(input logic d);   return d ? b_so   : a_so;   endfunction
  function automatic logic st_of(input logic d);   return d ? b_st   : a_st;   endfunction
  function automatic logic busy_of(input logic d); return d ? b_busy : a_busy; endfunction
  function automatic logic src_of(input logic d);  return d ? b_src  : a_src;  endfunction

  function automatic int exp_bit(input logic [7:0] dat, input int k);
    if (k < W) return int'(dat[W-1-k]);
    return int'(^dat);
  endfunction

  task automatic expect_frame(input int dut, input int src, input logic [7:0] d,
                              input int sp, input int nb);
    frame_t f;
    f.dut = dut; f.src = src; f.data = d; f.spacing = sp; f.nbits = nb;
    exp_q.push_back(f);
  endtask

  // Handshake bookkeeping and the ready-only-in-IDLE rule.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_r0v && a_r0r) begin hs_a++; last_hs[0] = cyc; end
      if (a_r1v && a_r1r) begin hs_a++; last_hs[0] = cyc; end
      if (b_r0v && b_r0r) begin hs_b++; last_hs[1] = cyc; end
      if (b_r1v && b_r1r) begin hs_b++; last_hs[1] = cyc; end
      if (a_r0r) rdy_a0++;
      if (a_r1r) rdy_a1++;
      if (a_busy) chk("ready_while_busy_a", int'(a_r0r | a_r1r), 0);
      if (b_busy) chk("ready_while_busy_b", int'(b_r0r | b_r1r), 0);
    end
  end

  // Monitor: one scoreboard entry per observed start pulse.
  initial begin : monitor
    frame_t f;
    logic   d;
    forever begin
      @(negedge clk);
      if (rst_n && (a_st || b_st)) begin
        mon_busy = 1'b1;
        d = b_st;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: dut %0d started a frame, none expected (cycle %0d)", d, cyc);
        end else begin
          f = exp_q.pop_front();
          chk("frame_dut", int'(d), f.dut);
          chk("src_id", int'(src_of(d)), f.src);
          chk("grant_to_start", cyc - last_hs[d], 1);
          if (f.spacing != 0) chk("start_spacing", cyc - last_start[d], f.spacing);
          last_start[d] = cyc;
          for (int k = 0; k < f.nbits; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("bit%0d", k), int'(so_of(d)), exp_bit(f.data, k));
            chk($sformatf("start_at_bit%0d", k), int'(st_of(d)), int'(k == 0));
            chk($sformatf("busy_at_bit%0d", k), int'(busy_of(d)), 1);
          end
          if (f.nbits == FLEN) begin
            for (int g = 0; g < (d ? GAP_B : GAP_A); g++) begin
              @(negedge clk);
              chk("gap_busy", int'(busy_of(d)), 1);
              chk("gap_serial", int'(so_of(d)), 0);
              chk("gap_start", int'(st_of(d)), 0);
            end
            @(negedge clk);
            chk("idle_busy", int'(busy_of(d)), 0);
            chk("idle_serial", int'(so_of(d)), 0);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Presents the given valids/data, waits for n handshakes, then withdraws
  // valid and scrambles data (the DUT must already have captured it).
  task automatic hold(input int dut, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1, input int n);
    int base;
    int got = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    base = (dut == 0) ? hs_a : hs_b;
    if (dut == 0) begin a_r0v = v0; a_r0d = d0; a_r1v = v1; a_r1d = d1; end
    else          begin b_r0v = v0; b_r0d = d0; b_r1v = v1; b_r1d = d1; end
    for (int i = 0; i < 30 * n && !done; i++) begin
      @(posedge clk); #1;
      got = ((dut == 0) ? hs_a : hs_b) - base;
      if (got >= n) done = 1'b1;
    end
    a_r0v = 1'b0; a_r1v = 1'b0; a_r0d = 8'h00; a_r1d = 8'h00;
    b_r0v = 1'b0; b_r1v = 1'b0; b_r0d = 8'h00; b_r1d = 8'h00;
    chk("handshakes", got, n);
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_q.size() != 0 || mon_busy) && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("frames_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int r0, r1, found;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_serial", int'(a_so), 0);
    chk("rst_start", int'(a_st), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_src", int'(a_src), 0);
    chk("rst_ready0", int'(a_r0r), 0);
    chk("rst_ready1", int'(a_r1r), 0);
    chk("rst_busy_b", int'(b_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(a_busy), 0);

    // Single requester 0 word 0xA5 from reset; data scrambled after ready.
    r0 = rdy_a0;
    expect_frame(0, 0, 8'hA5, 0, FLEN);
    hold(0, 1'b1, 8'hA5, 1'b0, 8'h00, 1);
    drain();
    chk("t1_ready0_pulses", rdy_a0 - r0, 1);

    // Both valid from reset: requester 0 first, then 1.
    apply_reset();
    expect_frame(0, 0, 8'h3C, 0, FLEN);
    expect_frame(0, 1, 8'hC3, SP_A, FLEN);
    hold(0, 1'b1, 8'h3C, 1'b1, 8'hC3, 2);
    drain();

    // Six frames with both held valid: strict alternation 0,1,0,1,0,1.
    r0 = rdy_a0;
    r1 = rdy_a1;
    expect_frame(0, 0, 8'h5A, 0, FLEN);
    expect_frame(0, 1, 8'h96, SP_A, FLEN);
    expect_frame(0, 0, 8'h5A, SP_A, FLEN);
    expect_frame(0, 1, 8'h96, SP_A, FLEN);
    expect_frame(0, 0, 8'h5A, SP_A, FLEN);
    expect_frame(0, 1, 8'h96, SP_A, FLEN);
    hold(0, 1'b1, 8'h5A, 1'b1, 8'h96, 6);
    drain();
    chk("t3_ready0_pulses", rdy_a0 - r0, 3);
    chk("t3_ready1_pulses", rdy_a1 - r1, 3);

    // Reset after the third bit of a 0xFF frame; then requester 0 wins again.
    expect_frame(0, 0, 8'hFF, 0, 3);
    hold(0, 1'b1, 8'hFF, 1'b0, 8'h00, 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (a_st) found = 1;
    end
    chk("t4_start_seen", found, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_serial", int'(a_so), 0);
    chk("t4_async_start", int'(a_st), 0);
    chk("t4_async_busy", int'(a_busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_frame(0, 0, 8'h6B, 0, FLEN);
    expect_frame(0, 1, 8'hD4, SP_A, FLEN);
    hold(0, 1'b1, 8'h6B, 1'b1, 8'hD4, 2);
    drain();

    // Parity-relevant frames: requester 1 sends 0x07 twice.
    expect_frame(0, 1, 8'h07, 0, FLEN);
    expect_frame(0, 1, 8'h07, SP_A, FLEN);
    hold(0, 1'b0, 8'h00, 1'b1, 8'h07, 2);
    drain();

    // GAP_CYCLES=0 instance: 0x81 frames separated only by the IDLE cycle.
    expect_frame(1, 0, 8'h81, 0, FLEN);
    expect_frame(1, 0, 8'h81, SP_B, FLEN);
    expect_frame(1, 0, 8'h81, SP_B, FLEN);
    hold(1, 1'b1, 8'h81, 1'b0, 8'h00, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
